sync_fifo_reader: RTL
=====================

# sync_fifo_reader

Read-side controller for `sync_fifo`. It pops words through the FIFO's `rd_en`/`dout`/`empty` port, absorbs the FIFO's one-cycle read latency, and presents the words as a valid/ready stream with burst framing (`m_last`). It sits between `sync_fifo` and any downstream consumer that can apply backpressure. With `m_ready` held high it sustains one word per cycle.

## Interface
- `DATA_WIDTH`, 8: word width; must match the attached `sync_fifo`.
- `BURST_LEN`, 8: `m_last` marks every `BURST_LEN`-th word; must be ≥1.
- `CNT_WIDTH`, 16: width of `word_count`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  high: new FIFO reads may issue; low: no new reads, in-flight and buffered words still drain.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_dout`  in  DATA_WIDTH  FIFO read data; valid in the cycle after the edge that popped it.
- `fifo_rd_en`  out  1  pop request to the FIFO (combinational).
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  consumer accepts the word.
- `m_data`  out  DATA_WIDTH  stream word.
- `m_last`  out  1  the current word is the last of a burst.
- `word_count`  out  CNT_WIDTH  number of completed stream handshakes (wraps).
- `idle`  out  1  nothing buffered or in flight.

## Operation
- State:
  - `inflight`, 0/1: a pop was issued at the previous edge.
  - `occ`, 0..2: skid-buffer occupancy.
  - `burst_idx`, 0..BURST_LEN-1.
  - `word_count`.
- `pop` = `m_valid && m_ready`.
- Read issue: `fifo_rd_en = enable && !fifo_empty && (occ + inflight <= 1 || (occ + inflight == 2 && pop))`.
  - This guarantees `occ + inflight` never exceeds 2 after any edge, so no overflow is possible.
- Issue edge (`fifo_rd_en` sampled high):
  - Set `inflight` = 1.
  - Tag the word `last = (burst_idx == BURST_LEN-1)`.
  - Advance `burst_idx`, wrapping to 0 after `BURST_LEN-1`.
- Capture edge (`inflight` = 1): write `{fifo_dout, tag}` into the buffer tail. Clear `inflight` unless a new issue occurs on the same edge.
- Buffer:
  - 2-entry, in-order.
  - `m_valid = (occ != 0)`.
  - `m_data` and `m_last` come from the head entry.
  - On an edge with both capture and `pop`, head advances and tail writes; `occ` is unchanged.
- Stream rule: while `m_valid && !m_ready`, `m_data` and `m_last` hold stable. `m_valid` never drops without a handshake.
- `word_count` increments on each `pop`; it wraps from 2^CNT_WIDTH−1 to 0.
- `idle = (occ == 0 && inflight == 0)`.
- `enable` low: `fifo_rd_en` is 0. A pending capture still completes and buffered words still stream. `burst_idx` is retained.
- `fifo_empty` high: no issue. The block never pops an empty FIFO.

## Timing
- Reset (`rst_n` low, asynchronous): all of the following clear immediately.
  - `occ`, `inflight`, `burst_idx`, `word_count` → 0.
  - `m_valid`, `m_last`, `idle`-complement → 0; `idle` = 1.
  - `m_data` → 0.
  - `fifo_rd_en` is forced 0 combinationally while `rst_n` is low.
- Reset mid-operation: an in-flight FIFO word is discarded; the FIFO has already popped it. That loss is accepted and must be documented at system level.
- Latency:
  - Cycle C0: `fifo_rd_en` high; edge E0 pops.
  - Edge E1: capture.
  - Cycle C2: `m_valid` high, two cycles after `fifo_rd_en`.
- Throughput: with `m_ready` high and the FIFO non-empty, `fifo_rd_en` and `m_valid` are high every cycle after fill, with no bubbles.
- Backpressure: `m_ready` low for N cycles stops issue within that same cycle once `occ + inflight == 2`. No data is dropped.
- `m_ready` high while `m_valid` is low has no effect.

## Structure
- Shared package `fifo_pkg`:
  - `DATA_WIDTH` default.
  - Buffer-entry struct `{data, last}`.
  - Occupancy-width localparam (2 bits).
- Sub-module `reader_skid_buf`: 2-entry buffer with `wr`/`rd` strobes, `occ` output, and head data/last.
- Top-level holds the issue logic, `inflight`, `burst_idx`, and `word_count`.

## Test plan
- Fill the FIFO with 10..17, `enable` = 1, `m_ready` = 1:
  - Stream 10..17 on 8 consecutive cycles.
  - `m_last` only on 17.
  - `word_count` = 8.
  - `idle` = 1 at end.
- Same fill, `m_ready` low for 5 cycles after the first word:
  - Stream 10,11,…,17 in order with no duplicates or loss.
  - `fifo_rd_en` never high while `occ + inflight == 2` and `pop` = 0.
- FIFO empty, `enable` = 1: `fifo_rd_en` stays 0 and `m_valid` stays 0. Then write a single 0xA5: `m_valid` rises exactly 2 cycles after `fifo_rd_en` with `m_data` = 0xA5.
- `BURST_LEN` = 3, 7 words 1..7: `m_last` on 3 and 6 only. Drop `enable` after word 4 issues: words 5..7 wait. Re-enable: word 6 still carries `m_last`.
- Assert `rst_n` low mid-stream with `occ` = 2:
  - `m_valid`, `word_count`, `fifo_rd_en` go 0 immediately, before the next clock edge.
  - After release, the remaining FIFO words stream correctly and `burst_idx` restarts at 0.
- `CNT_WIDTH` = 4, 17 words: `word_count` wraps to 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and constants for the sync_fifo read-side slice.
package fifo_pkg;

   localparam int unsigned FIFO_DATA_WIDTH = 8;
   localparam int unsigned OCC_WIDTH       = 2;

   typedef struct packed {
      logic [FIFO_DATA_WIDTH-1:0] data;
      logic                       last;
   } buf_entry_t;

endpackage

// File: rtl/reader_skid_buf.sv
// Two-entry in-order skid buffer absorbing the FIFO read latency.
module reader_skid_buf
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_last,
   input  logic                  rd,
   output logic [OCC_WIDTH-1:0]  occ,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  head_last
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
   } entry_t;

   entry_t               head_q, head_d, tail_q, tail_d, in_e;
   logic [OCC_WIDTH-1:0] occ_q, occ_d;

   // A write into a full buffer cannot occur: the issue logic caps occ + inflight at 2.
   always_comb begin
      in_e.data = wr_data;
      in_e.last = wr_last;
      head_d    = head_q;
      tail_d    = tail_q;
      occ_d     = occ_q;
      case (occ_q)
         2'd0: begin
            if (wr) begin
               head_d = in_e;
               occ_d  = 2'd1;
            end
         end
         2'd1: begin
            if (wr && rd) begin
               head_d = in_e;
            end else if (wr) begin
               tail_d = in_e;
               occ_d  = 2'd2;
            end else if (rd) begin
               occ_d  = 2'd0;
            end
         end
         default: begin
            if (rd) begin
               head_d = tail_q;
               if (wr) tail_d = in_e;
               else    occ_d  = 2'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   assign occ       = occ_q;
   assign head_data = head_q.data;
   assign head_last = head_q.last;

endmodule

// File: rtl/sync_fifo_reader.sv
// Pops sync_fifo words and presents them as a framed valid/ready stream.
// A word in flight when rst_n asserts is lost; the FIFO has already popped it.
module sync_fifo_reader
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int unsigned BURST_LEN  = 8,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic [CNT_WIDTH-1:0]  word_count,
   output logic                  idle
);

   localparam int unsigned          BI_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BI_W-1:0]      BI_LAST = BI_W'(BURST_LEN - 1);
   localparam logic [OCC_WIDTH:0]   OUT_ONE = (OCC_WIDTH+1)'(1);
   localparam logic [OCC_WIDTH:0]   OUT_TWO = (OCC_WIDTH+1)'(2);

   logic                 inflight_q, inflight_d;
   logic                 tag_q, tag_d;
   logic [BI_W-1:0]      burst_idx_q, burst_idx_d;
   logic [CNT_WIDTH-1:0] word_count_q, word_count_d;
   logic [OCC_WIDTH-1:0] occ;
   logic [OCC_WIDTH:0]   outstanding;
   logic                 pop;
   logic                 head_last;

   assign pop         = m_valid && m_ready;
   assign outstanding = {1'b0, occ} + {{OCC_WIDTH{1'b0}}, inflight_q};

   // rst_n gates the pop so an asserted reset never consumes a FIFO word.
   assign fifo_rd_en = rst_n && enable && !fifo_empty &&
                       ((outstanding <= OUT_ONE) || ((outstanding == OUT_TWO) && pop));

   always_comb begin
      inflight_d   = fifo_rd_en;
      tag_d        = tag_q;
      burst_idx_d  = burst_idx_q;
      word_count_d = word_count_q + CNT_WIDTH'(pop);
      if (fifo_rd_en) begin
         tag_d       = (burst_idx_q == BI_LAST);
         burst_idx_d = (burst_idx_q == BI_LAST) ? '0 : burst_idx_q + BI_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q   <= 1'b0;
         tag_q        <= 1'b0;
         burst_idx_q  <= '0;
         word_count_q <= '0;
      end else begin
         inflight_q   <= inflight_d;
         tag_q        <= tag_d;
         burst_idx_q  <= burst_idx_d;
         word_count_q <= word_count_d;
      end
   end

   reader_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr        (inflight_q),
      .wr_data   (fifo_dout),
      .wr_last   (tag_q),
      .rd        (pop),
      .occ       (occ),
      .head_data (m_data),
      .head_last (head_last)
   );

   assign m_valid    = (occ != '0);
   assign m_last     = head_last;
   assign word_count = word_count_q;
   assign idle       = (occ == '0) && !inflight_q;

endmodule
